// File: rtl/dsp48_add_arbiter.sv
// dsp48_add_arbiter: round-robin scheduler sharing one pipelined DSP48 adder.
// Requesters hand over (a, d) pairs over valid/ready. Each issued op carries
// its requester ID down a tag pipe that lines up with the adder latency, and
// results land in a show-ahead FIFO. A credit counter bounds in-flight ops
// plus FIFO occupancy, so the adder never needs backpressure.
// Optional build macro DSP48_ADD_ARB_STATS_EN adds the stall_cnt output.
module dsp48_add_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 16,
   parameter int ADD_LAT    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ*DATA_W-1:0]     req_a,
   input  logic [N_REQ*DATA_W-1:0]     req_d,
   output logic [DATA_W-1:0]           add_a,
   output logic [DATA_W-1:0]           add_d,
   input  logic [DATA_W-1:0]           add_p,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [$clog2(N_REQ)-1:0]    res_id,
   output logic [DATA_W-1:0]           res_p
`ifdef DSP48_ADD_ARB_STATS_EN
   ,
   output logic [31:0]                 stall_cnt
`endif
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);

   logic [ID_W-1:0]   rr_ptr;
   logic [CW-1:0]     credits;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   cand;
   logic              hs;
   logic              pop;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_d;

   logic [ADD_LAT:0]  tag_v;
   logic [ID_W-1:0]   tag_id [ADD_LAT+1];

   logic [ID_W-1:0]   fifo_id [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_p  [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_cnt;
   logic              fifo_wr;

   // Round-robin search starting just after the last grantee; no grant without credit
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      if (credits != '0) begin
         for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_id    = cand;
            end
         end
      end
   end

   // One-hot ready for the grantee and operand select
   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_d     = '0;
      if (gnt_found) req_ready[gnt_id] = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_id == ID_W'(i)) begin
            sel_a = req_a[i*DATA_W +: DATA_W];
            sel_d = req_d[i*DATA_W +: DATA_W];
         end
      end
   end

   assign hs        = |(req_valid & req_ready);
   assign res_valid = (fifo_cnt != '0);
   assign pop       = res_valid & res_ready;
   assign fifo_wr   = tag_v[ADD_LAT];
   assign res_id    = fifo_id[rd_ptr];
   assign res_p     = fifo_p[rd_ptr];

   // Arbiter pointer and credit accounting; grant+pop in one cycle cancel out
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr  <= ID_W'(N_REQ - 1);
         credits <= CW'(FIFO_DEPTH);
      end else begin
         if (hs) rr_ptr <= gnt_id;
         case ({hs, pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
      end
   end

   // Issue registers hold their last value when no op is granted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         add_a <= '0;
         add_d <= '0;
      end else if (hs) begin
         add_a <= sel_a;
         add_d <= sel_d;
      end
   end

   // Tag pipe: stage ADD_LAT is valid in the cycle add_p carries that op's result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_v <= '0;
         for (int k = 0; k <= ADD_LAT; k++) tag_id[k] <= '0;
      end else begin
         tag_v     <= {tag_v[ADD_LAT-1:0], hs};
         tag_id[0] <= gnt_id;
         for (int k = 1; k <= ADD_LAT; k++) tag_id[k] <= tag_id[k-1];
      end
   end

   // Result FIFO; head entry is presented directly from storage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            fifo_id[k] <= '0;
            fifo_p[k]  <= '0;
         end
      end else begin
         if (fifo_wr) begin
            fifo_id[wr_ptr] <= tag_id[ADD_LAT];
            fifo_p[wr_ptr]  <= add_p;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({fifo_wr, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

`ifdef DSP48_ADD_ARB_STATS_EN
   // Saturating count of cycles where someone wants service but credits are exhausted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if ((|req_valid) && (credits == '0) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
